// File: rtl/ysyx_22040895_csr_file.sv
// M-mode CSR file: CSRRW/RS/RC, trap entry and mret, trap vector. Reads are combinational, writes commit at posedge.
// Optional mcycle counter at 0xB00 is built when YSYX_22040895_CSR_MCYCLE_EN is defined.
module ysyx_22040895_csr_file #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              VECTORED    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_req_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [1:0]  OP_RW         = 2'b01;
  localparam logic [1:0]  OP_RS         = 2'b10;
  localparam logic [1:0]  OP_RC         = 2'b11;

  // Field rules also apply to the reset value so reads never expose a reserved bit.
  localparam logic [XLEN-1:0] MTVEC_RST_VAL =
    {MTVEC_RESET[XLEN-1:2], 1'b0, (VECTORED ? MTVEC_RESET[0] : 1'b0)};

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] tvec_base;
  logic            addr_hit;
  logic            wr_en;

`ifdef YSYX_22040895_CSR_MCYCLE_EN
  localparam logic [11:0]     ADDR_MCYCLE = 12'hB00;
  localparam logic [XLEN-1:0] CNT_ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  logic [XLEN-1:0] mcycle_q, mcycle_d;
`endif

  // MPP is hardwired to machine mode; only MIE and MPIE hold state.
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  always_comb begin
    addr_hit = 1'b1;
    old_val  = '0;
    case (csr_addr_i)
      ADDR_MSTATUS:  old_val = mstatus_rd;
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
`ifdef YSYX_22040895_CSR_MCYCLE_EN
      ADDR_MCYCLE:   old_val = mcycle_q;
`endif
      default:       addr_hit = 1'b0;
    endcase
  end

  assign csr_rdata_o   = (csr_req_i && addr_hit) ? old_val : '0;
  assign csr_illegal_o = csr_req_i && !addr_hit;

  always_comb begin
    case (csr_op_i)
      OP_RW:   new_val = csr_wdata_i;
      OP_RS:   new_val = old_val | csr_wdata_i;
      OP_RC:   new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero operand is a pure read; trap and mret squash the write.
  assign wr_en = csr_req_i && addr_hit && (csr_op_i != 2'b00)
              && ((csr_op_i == OP_RW) || (csr_wdata_i != '0))
              && !trap_i && !mret_i;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_i) begin
      mepc_d   = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
        ADDR_MSTATUS: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        ADDR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 1'b0, (VECTORED ? new_val[0] : 1'b0)};
        ADDR_MSCRATCH: mscratch_d = new_val;
        ADDR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = new_val;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST_VAL;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef YSYX_22040895_CSR_MCYCLE_EN
  // A committed write replaces that cycle's increment; counting resumes afterwards.
  always_comb begin
    mcycle_d = mcycle_q + CNT_ONE;
    if (wr_en && (csr_addr_i == ADDR_MCYCLE)) mcycle_d = new_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcycle_q <= '0;
    else     mcycle_q <= mcycle_d;
  end
`endif

  // Vectored mode applies only to interrupts; exceptions always land on the base.
  always_comb begin
    tvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
    trap_vec_o = tvec_base;
    if (VECTORED && (mtvec_q[1:0] == 2'b01) && trap_cause_i[XLEN-1])
      trap_vec_o = tvec_base + {{(XLEN-8){1'b0}}, trap_cause_i[5:0], 2'b00};
  end

  assign mepc_o = mepc_q;
  assign mie_o  = mie_q;

endmodule

// File: tb/tb_ysyx_22040895_csr_file.sv
// Self-checking bench for ysyx_22040895_csr_file: directed scenarios plus randomized traffic against an architectural model.
module tb_ysyx_22040895_csr_file;

  localparam logic [63:0] MTV_RST = 64'h0000_0000_2000_0100;

  logic        clk;
  logic        rst;
  logic        csr_req_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        trap_i;
  logic [63:0] trap_cause_i;
  logic [63:0] trap_pc_i;
  logic        mret_i;
  logic [63:0] trap_vec_o;
  logic [63:0] mepc_o;
  logic        mie_o;

  int checks = 0;
  int errors = 0;

  // Architectural model: whole register values as software would see them.
  logic [63:0] m_status, m_tvec, m_scratch, m_epc, m_cause;

  ysyx_22040895_csr_file #(.XLEN(64), .MTVEC_RESET(MTV_RST), .VECTORED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .csr_req_i(csr_req_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .mret_i(mret_i),
    .trap_vec_o(trap_vec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_legal(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
`ifdef YSYX_22040895_CSR_MCYCLE_EN
      12'hB00: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] m_vec(input logic [63:0] cause);
    logic [63:0] base;
    base = m_tvec & ~64'h3;
    if (m_tvec[1:0] == 2'b01 && cause[63]) return base + 64'(cause[5:0]) * 4;
    return base;
  endfunction

  task automatic m_reset();
    m_status = 64'h1800; m_tvec = MTV_RST; m_scratch = 0; m_epc = 0; m_cause = 0;
  endtask

  // Applies what the coming clock edge should commit, given the inputs now driven.
  task automatic m_step();
    logic [63:0] old, nv;
    if (trap_i) begin
      m_epc   = trap_pc_i & ~64'h3;
      m_cause = trap_cause_i;
      m_status = 64'h1800 | (m_status[3] ? 64'h80 : 64'h0);
    end else if (mret_i) begin
      m_status = 64'h1880 | (m_status[7] ? 64'h8 : 64'h0);
    end else if (csr_req_i && m_legal(csr_addr_i) && csr_op_i != 2'b00 &&
                 (csr_op_i == 2'b01 || csr_wdata_i != 0)) begin
      old = m_read(csr_addr_i);
      nv = (csr_op_i == 2'b01) ? csr_wdata_i :
           (csr_op_i == 2'b10) ? (old | csr_wdata_i) : (old & ~csr_wdata_i);
      case (csr_addr_i)
        12'h300: m_status  = 64'h1800 | (nv & 64'h88);
        12'h305: m_tvec    = nv & ~64'h2;
        12'h340: m_scratch = nv;
        12'h341: m_epc     = nv & ~64'h3;
        12'h342: m_cause   = nv;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic req, input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    csr_req_i = req; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
    trap_i = 1'b0; mret_i = 1'b0;
    #3;
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    csr_req_i = 1'b0; csr_op_i = 2'b00; trap_i = 1'b0; mret_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 12'h300, 64'h0);
    trap_pc_i = 0; trap_cause_i = 0;
    #3;
    checks++; if (csr_rdata_o !== 64'h0) begin errors++; $display("FAIL reset_rdata_idle: got %h want 0", csr_rdata_o); end
    checks++; if (mie_o !== 1'b0) begin errors++; $display("FAIL reset_mie: got %b want 0", mie_o); end
    checks++; if (csr_illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal_idle: got %b want 0", csr_illegal_o); end
    #6 rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 12'h300, 64'h0);
    checks++; if (csr_rdata_o !== 64'h1800) begin errors++; $display("FAIL reset_mstatus: got %h want 1800", csr_rdata_o); end
    drive(1'b1, 2'b00, 12'h305, 64'h0);
    checks++; if (csr_rdata_o !== MTV_RST) begin errors++; $display("FAIL reset_mtvec: got %h want %h", csr_rdata_o, MTV_RST); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 12'h340 + 12'(i), 64'h0);
      checks++; if (csr_rdata_o !== 64'h0) begin errors++; $display("FAIL reset_csr_%0d: got %h want 0", i, csr_rdata_o); end
    end
    step();
  endtask

  task automatic test_rw_scratch();
    drive(1'b1, 2'b01, 12'h340, 64'hDEAD_BEEF);
    checks++; if (csr_rdata_o !== 64'h0) begin errors++; $display("FAIL rw_old: got %h want 0", csr_rdata_o); end
    step();
    drive(1'b1, 2'b10, 12'h340, 64'hF0);
    checks++; if (csr_rdata_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rs_old: got %h want deadbeef", csr_rdata_o); end
    step();
    drive(1'b1, 2'b11, 12'h340, 64'hFF);
    checks++; if (csr_rdata_o !== 64'hDEAD_BEFF) begin errors++; $display("FAIL rc_old: got %h want deadbeff", csr_rdata_o); end
    step();
    drive(1'b1, 2'b00, 12'h340, 64'h0);
    checks++; if (csr_rdata_o !== 64'hDEAD_BE00) begin errors++; $display("FAIL rc_result: got %h want deadbe00", csr_rdata_o); end
    step();
  endtask

  task automatic test_fields();
    drive(1'b1, 2'b01, 12'h300, '1);
    step();
    drive(1'b1, 2'b00, 12'h300, 64'h0);
    checks++; if (csr_rdata_o !== 64'h1888) begin errors++; $display("FAIL mstatus_mask: got %h want 1888", csr_rdata_o); end
    checks++; if (mie_o !== 1'b1) begin errors++; $display("FAIL mstatus_mie_o: got %b want 1", mie_o); end
    step();
    drive(1'b1, 2'b01, 12'h341, 64'h8000_0007);
    step();
    drive(1'b1, 2'b00, 12'h341, 64'h0);
    checks++; if (csr_rdata_o !== 64'h8000_0004) begin errors++; $display("FAIL mepc_mask: got %h want 80000004", csr_rdata_o); end
    checks++; if (mepc_o !== 64'h8000_0004) begin errors++; $display("FAIL mepc_o: got %h want 80000004", mepc_o); end
    step();
    drive(1'b1, 2'b01, 12'h305, 64'h1234_5677);
    step();
    drive(1'b1, 2'b00, 12'h305, 64'h0);
    checks++; if (csr_rdata_o !== 64'h1234_5675) begin errors++; $display("FAIL mtvec_mask: got %h want 12345675", csr_rdata_o); end
    step();
  endtask

  task automatic test_trap_mret();
    drive(1'b1, 2'b10, 12'h300, 64'h8);
    step();
    drive(1'b0, 2'b00, 12'h000, 64'h0);
    trap_i = 1'b1; trap_pc_i = 64'h8000_0100; trap_cause_i = 64'd11;
    step();
    drive(1'b1, 2'b00, 12'h341, 64'h0);
    checks++; if (csr_rdata_o !== 64'h8000_0100) begin errors++; $display("FAIL trap_mepc: got %h want 80000100", csr_rdata_o); end
    drive(1'b1, 2'b00, 12'h342, 64'h0);
    checks++; if (csr_rdata_o !== 64'd11) begin errors++; $display("FAIL trap_mcause: got %h want b", csr_rdata_o); end
    drive(1'b1, 2'b00, 12'h300, 64'h0);
    checks++; if (csr_rdata_o !== 64'h1880) begin errors++; $display("FAIL trap_mstatus: got %h want 1880", csr_rdata_o); end
    checks++; if (mie_o !== 1'b0) begin errors++; $display("FAIL trap_mie_o: got %b want 0", mie_o); end
    drive(1'b0, 2'b00, 12'h000, 64'h0);
    mret_i = 1'b1;
    step();
    drive(1'b1, 2'b00, 12'h300, 64'h0);
    checks++; if (mie_o !== 1'b1) begin errors++; $display("FAIL mret_mie_o: got %b want 1", mie_o); end
    checks++; if (csr_rdata_o !== 64'h1888) begin errors++; $display("FAIL mret_mstatus: got %h want 1888", csr_rdata_o); end
    checks++; if (mepc_o !== 64'h8000_0100) begin errors++; $display("FAIL mret_mepc_o: got %h want 80000100", mepc_o); end
    step();
  endtask

  task automatic test_vectored();
    drive(1'b1, 2'b01, 12'h305, 64'h8000_0001);
    step();
    drive(1'b0, 2'b00, 12'h000, 64'h0);
    trap_cause_i = 64'h8000_0000_0000_0007; #1;
    checks++; if (trap_vec_o !== 64'h8000_001C) begin errors++; $display("FAIL vec_irq: got %h want 8000001c", trap_vec_o); end
    trap_cause_i = 64'd2; #1;
    checks++; if (trap_vec_o !== 64'h8000_0000) begin errors++; $display("FAIL vec_exc: got %h want 80000000", trap_vec_o); end
    drive(1'b1, 2'b01, 12'h305, 64'h8000_0100);
    step();
    trap_cause_i = 64'h8000_0000_0000_0007; #1;
    checks++; if (trap_vec_o !== 64'h8000_0100) begin errors++; $display("FAIL vec_direct: got %h want 80000100", trap_vec_o); end
  endtask

  task automatic test_priority();
    drive(1'b1, 2'b01, 12'h341, 64'h1234);
    trap_i = 1'b1; trap_pc_i = 64'h4000_0008; trap_cause_i = 64'd5;
    #1;
    checks++; if (csr_rdata_o !== 64'h8000_0100) begin errors++; $display("FAIL prio_rdata: got %h want 80000100", csr_rdata_o); end
    step();
    drive(1'b1, 2'b00, 12'h341, 64'h0);
    checks++; if (csr_rdata_o !== 64'h4000_0008) begin errors++; $display("FAIL prio_trap_mepc: got %h want 40000008", csr_rdata_o); end
    drive(1'b1, 2'b01, 12'h340, 64'h55);
    mret_i = 1'b1;
    step();
    drive(1'b1, 2'b00, 12'h340, 64'h0);
    checks++; if (csr_rdata_o !== 64'hDEAD_BE00) begin errors++; $display("FAIL prio_mret_squash: got %h want deadbe00", csr_rdata_o); end
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b01, 12'h7C0, 64'hFFFF);
    checks++; if (csr_illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", csr_illegal_o); end
    checks++; if (csr_rdata_o !== 64'h0) begin errors++; $display("FAIL illegal_rdata: got %h want 0", csr_rdata_o); end
    step();
    drive(1'b1, 2'b00, 12'hB00, 64'h0);
`ifdef YSYX_22040895_CSR_MCYCLE_EN
    checks++; if (csr_illegal_o !== 1'b0) begin errors++; $display("FAIL mcycle_legal: got %b want 0", csr_illegal_o); end
`else
    checks++; if (csr_illegal_o !== 1'b1) begin errors++; $display("FAIL mcycle_illegal: got %b want 1", csr_illegal_o); end
`endif
    step();
  endtask

`ifdef YSYX_22040895_CSR_MCYCLE_EN
  task automatic test_mcycle();
    drive(1'b1, 2'b01, 12'hB00, '1);
    step();
    drive(1'b1, 2'b00, 12'hB00, 64'h0);
    checks++; if (csr_rdata_o !== '1) begin errors++; $display("FAIL mcycle_load: got %h want all-ones", csr_rdata_o); end
    step();
    drive(1'b1, 2'b00, 12'hB00, 64'h0);
    checks++; if (csr_rdata_o !== 64'h0) begin errors++; $display("FAIL mcycle_wrap: got %h want 0", csr_rdata_o); end
    step();
    drive(1'b1, 2'b00, 12'hB00, 64'h0);
    checks++; if (csr_rdata_o !== 64'h1) begin errors++; $display("FAIL mcycle_inc: got %h want 1", csr_rdata_o); end
    step();
  endtask
`endif

  task automatic test_random();
    logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'h343};
    logic [63:0] exp_rd;
    for (int n = 0; n < 400; n++) begin
      csr_req_i   = ($urandom_range(0, 4) != 0);
      csr_op_i    = 2'($urandom_range(0, 3));
      csr_addr_i  = addrs[$urandom_range(0, 6)];
      csr_wdata_i = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      trap_i      = ($urandom_range(0, 7) == 0);
      mret_i      = ($urandom_range(0, 7) == 0);
      trap_cause_i = {$urandom, $urandom};
      trap_pc_i    = {$urandom, $urandom};
      #3;
      exp_rd = (csr_req_i && m_legal(csr_addr_i)) ? m_read(csr_addr_i) : 64'h0;
      checks++; if (csr_rdata_o !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: addr %h got %h want %h", n, csr_addr_i, csr_rdata_o, exp_rd); end
      checks++; if (csr_illegal_o !== (csr_req_i && !m_legal(csr_addr_i))) begin errors++; $display("FAIL rnd_illegal[%0d]: got %b", n, csr_illegal_o); end
      checks++; if (trap_vec_o !== m_vec(trap_cause_i)) begin errors++; $display("FAIL rnd_trapvec[%0d]: got %h want %h", n, trap_vec_o, m_vec(trap_cause_i)); end
      checks++; if (mepc_o !== m_epc) begin errors++; $display("FAIL rnd_mepc[%0d]: got %h want %h", n, mepc_o, m_epc); end
      checks++; if (mie_o !== m_status[3]) begin errors++; $display("FAIL rnd_mie[%0d]: got %b want %b", n, mie_o, m_status[3]); end
      step();
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 2'b01, 12'h340, 64'h77);
    step();
    drive(1'b1, 2'b00, 12'h340, 64'h0);
    rst = 1'b1; #1;
    checks++; if (csr_rdata_o !== 64'h0) begin errors++; $display("FAIL midrst_mscratch: got %h want 0", csr_rdata_o); end
    csr_addr_i = 12'h300; #1;
    checks++; if (csr_rdata_o !== 64'h1800) begin errors++; $display("FAIL midrst_mstatus: got %h want 1800", csr_rdata_o); end
    csr_addr_i = 12'h305; #1;
    checks++; if (csr_rdata_o !== MTV_RST) begin errors++; $display("FAIL midrst_mtvec: got %h want %h", csr_rdata_o, MTV_RST); end
    checks++; if (mie_o !== 1'b0 || mepc_o !== 64'h0) begin errors++; $display("FAIL midrst_outs: mie %b mepc %h want 0 0", mie_o, mepc_o); end
    @(posedge clk); #2;
    rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    csr_req_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
    trap_i = 0; mret_i = 0; trap_cause_i = 0; trap_pc_i = 0; rst = 1'b1;
    m_reset();
    test_reset();
    test_rw_scratch();
    test_fields();
    test_trap_mret();
    test_vectored();
    test_priority();
    test_illegal();
`ifdef YSYX_22040895_CSR_MCYCLE_EN
    test_mcycle();
`endif
    test_random();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
